// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among 4 requesters.
// Latency: grant 1 cycle after the sampling edge, tagged read data 2 cycles after it.
// Backpressure: req is held until gnt; a just-granted requester is masked for one cycle.
module regfile_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req,
    input  logic [4*ADDR_WIDTH-1:0] req_addr,
    output logic [3:0]              gnt,
    output logic                    rf_ren,
    output logic [ADDR_WIDTH-1:0]   rf_raddr,
    output logic [1:0]              rf_sel,
    input  logic [DATA_WIDTH-1:0]   rf_rdata,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [3:0]              rd_valid
);

    logic [3:0]            gnt_q, gnt_d;
    logic                  rf_ren_q, rf_ren_d;
    logic [ADDR_WIDTH-1:0] rf_raddr_q, rf_raddr_d;
    logic [1:0]            rf_sel_q, rf_sel_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [3:0]            rd_valid_q, rd_valid_d;
    logic [1:0]            ptr_q, ptr_d;

    logic [3:0] elig;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    // Masking the current grant keeps a held req from being granted on back-to-back cycles.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        gnt_d      = 4'b0000;
        rf_ren_d   = found;
        rf_raddr_d = rf_raddr_q;
        rf_sel_d   = rf_sel_q;
        ptr_d      = ptr_q;
        if (found) begin
            gnt_d[win] = 1'b1;
            rf_raddr_d = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            rf_sel_d   = win;
            ptr_d      = win + 2'd1;
        end
        rd_valid_d = gnt_q;
        rd_data_d  = rf_ren_q ? rf_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= 4'b0000;
            rf_ren_q   <= 1'b0;
            rf_raddr_q <= '0;
            rf_sel_q   <= 2'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 4'b0000;
            ptr_q      <= 2'd0;
        end else begin
            gnt_q      <= gnt_d;
            rf_ren_q   <= rf_ren_d;
            rf_raddr_q <= rf_raddr_d;
            rf_sel_q   <= rf_sel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign rf_ren   = rf_ren_q;
    assign rf_raddr = rf_raddr_q;
    assign rf_sel   = rf_sel_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
